// File: rtl/inst_loader_pkg.sv
// Shared codes for the instruction loader: record kinds, ALU commands,
// condition/op-class fields, fixed BX pattern and FSM states.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    KIND_DP_REG = 3'd0,
    KIND_DP_IMM = 3'd1,
    KIND_LDR    = 3'd2,
    KIND_STR    = 3'd3,
    KIND_B      = 3'd4,
    KIND_BL     = 3'd5,
    KIND_BX     = 3'd6,
    KIND_ILL    = 3'd7
  } kind_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] OPC_DP  = 2'b00;
  localparam logic [1:0] OPC_MEM = 2'b01;
  localparam logic [1:0] OPC_BR  = 2'b10;

  // Bits [25:20] of the memory-class word (I=0, P=1, U=1, B=0, W=0, L).
  localparam logic [5:0] MEM_LDR = 6'b011001;
  localparam logic [5:0] MEM_STR = 6'b011000;

  localparam logic [23:0] BX_PATTERN = 24'h12FFF1;

  // state    | meaning
  // ST_STOP  | after reset, waiting for START
  // ST_IDLE  | ready for a field record
  // ST_WRITE | one-cycle memory write of the registered word
  // ST_DONE  | program complete, waiting for START
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic cmd_legal(input logic [3:0] cmd);
    return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
           (cmd == CMD_CMP) || (cmd == CMD_ORR) || (cmd == CMD_MOV);
  endfunction

endpackage

// File: rtl/inst_loader_encode.sv
// Combinational field packer: turns one field record into a 32-bit
// instruction word and flags records that have no legal encoding.
module inst_encode
  import inst_loader_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [3:0]  cond_i,
  input  logic [3:0]  cmd_i,
  input  logic        s_i,
  input  logic [3:0]  rn_i,
  input  logic [3:0]  rd_i,
  input  logic [3:0]  rm_i,
  input  logic [11:0] imm12_i,
  input  logic [23:0] imm24_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic is_cmp;
  assign is_cmp = (cmd_i == CMD_CMP);

  // Pack fields by record kind; CMP always sets flags and has no destination.
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (kind_i)
      KIND_DP_REG, KIND_DP_IMM: begin
        if (!cmd_legal(cmd_i)) begin
          illegal_o = 1'b1;
        end else begin
          word_o[31:28] = cond_i;
          word_o[27:26] = OPC_DP;
          word_o[25]    = (kind_i == KIND_DP_IMM);
          word_o[24:21] = cmd_i;
          word_o[20]    = s_i | is_cmp;
          word_o[19:16] = rn_i;
          word_o[15:12] = is_cmp ? 4'd0 : rd_i;
          if (kind_i == KIND_DP_IMM) word_o[11:0] = imm12_i;
          else                       word_o[3:0]  = rm_i;
        end
      end
      KIND_LDR, KIND_STR: begin
        word_o[31:28] = cond_i;
        word_o[27:26] = OPC_MEM;
        word_o[25:20] = (kind_i == KIND_LDR) ? MEM_LDR : MEM_STR;
        word_o[19:16] = rn_i;
        word_o[15:12] = rd_i;
        word_o[11:0]  = imm12_i;
      end
      KIND_B, KIND_BL: begin
        word_o[31:28] = cond_i;
        word_o[27:26] = OPC_BR;
        word_o[25]    = 1'b1;
        word_o[24]    = (kind_i == KIND_BL);
        word_o[23:0]  = imm24_i;
      end
      KIND_BX: begin
        word_o[31:28] = cond_i;
        word_o[27:4]  = BX_PATTERN;
        word_o[3:0]   = rm_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: accepts field records, encodes them and writes the
// words to consecutive instruction-memory addresses starting at 0.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [2:0]             KIND,
  input  logic [3:0]             COND,
  input  logic [3:0]             CMD,
  input  logic                   S,
  input  logic [3:0]             RN,
  input  logic [3:0]             RD,
  input  logic [3:0]             RM,
  input  logic [11:0]            IMM12,
  input  logic [23:0]            IMM24,
  input  logic                   LAST,
  output logic                   MEM_WE,
  output logic [AW-1:0]          MEM_ADDR,
  output logic [31:0]            MEM_WDATA,
  output logic                   DONE,
  output logic                   ERR,
  output logic                   OVF,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] ADDR_WRAP = AW'((DEPTH - 1) * 4);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            last_q, last_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  logic [31:0]     enc_word;
  logic            enc_illegal;

  inst_encode u_encode (
    .kind_i    (KIND),
    .cond_i    (COND),
    .cmd_i     (CMD),
    .s_i       (S),
    .rn_i      (RN),
    .rd_i      (RD),
    .rm_i      (RM),
    .imm12_i   (IMM12),
    .imm24_i   (IMM24),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // Next-state, address/count bookkeeping and write-port capture.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_STOP, ST_DONE: begin
        if (START) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ST_IDLE: begin
        if (IN_VALID) begin
          if (enc_illegal) begin
            err_d   = 1'b1;
            state_d = LAST ? ST_DONE : ST_IDLE;
          end else begin
            mem_addr_d  = addr_q;
            mem_wdata_d = enc_word;
            last_d      = LAST;
            state_d     = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        count_d = count_q + CW'(1);
        if (addr_q == ADDR_WRAP) begin
          addr_d = '0;
          ovf_d  = 1'b1;
        end else begin
          addr_d = addr_q + AW'(4);
        end
        state_d = last_q ? ST_DONE : ST_IDLE;
      end
      default: state_d = ST_STOP;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_STOP;
      addr_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      last_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign MEM_WE    = (state_q == ST_WRITE);
  assign DONE      = (state_q == ST_DONE);
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign ERR       = err_q;
  assign OVF       = ovf_q;
  assign COUNT     = count_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: scoreboard of expected memory writes, pushed when
// a record is driven and popped when the write port fires.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic        CLK = 1'b0;
  logic        RESET, START, IN_VALID, S, LAST;
  logic        IN_READY, MEM_WE, DONE, ERR, OVF;
  logic [2:0]  KIND;
  logic [3:0]  COND, CMD, RN, RD, RM;
  logic [11:0] IMM12;
  logic [23:0] IMM24;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [$clog2(DEPTH):0] COUNT;

  int n_checks = 0;
  int n_errors = 0;
  logic [AW+31:0] sb_q[$];
  logic [AW-1:0]  addr_m;

  inst_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .KIND(KIND), .COND(COND), .CMD(CMD), .S(S),
    .RN(RN), .RD(RD), .RM(RM), .IMM12(IMM12), .IMM24(IMM24), .LAST(LAST),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .DONE(DONE), .ERR(ERR), .OVF(OVF), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every write the DUT performs must match the oldest expected write.
  always @(negedge CLK) begin
    if (MEM_WE === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        logic [AW+31:0] e;
        e = sb_q.pop_front();
        chk("mem_addr", 32'(MEM_ADDR), 32'(e[AW+31:32]));
        chk("mem_wdata", MEM_WDATA, e[31:0]);
      end
    end
  end

  task automatic start_prog();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    addr_m = '0;
    chk("ready_after_start", 32'(IN_READY), 32'd1);
  endtask

  task automatic send(input logic [2:0] k, input logic [3:0] c, input logic [3:0] cm,
                      input logic s_v, input logic [3:0] rn_v, input logic [3:0] rd_v,
                      input logic [3:0] rm_v, input logic [11:0] i12, input logic [23:0] i24,
                      input logic lst, input logic legal, input logic [31:0] w);
    int n;
    n = 0;
    while (IN_READY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    chk("ready_wait", 32'(IN_READY), 32'd1);
    KIND = k; COND = c; CMD = cm; S = s_v; RN = rn_v; RD = rd_v; RM = rm_v;
    IMM12 = i12; IMM24 = i24; LAST = lst; IN_VALID = 1'b1;
    if (legal) begin
      sb_q.push_back({addr_m, w});
      addr_m = (addr_m == AW'((DEPTH - 1) * 4)) ? '0 : addr_m + AW'(4);
    end
    @(negedge CLK);
    IN_VALID = 1'b0; LAST = 1'b0;
    chk("we_latency", 32'(MEM_WE), 32'(legal));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (DONE !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
    chk("done", 32'(DONE), 32'd1);
  endtask

  task automatic status(input string tag, input logic e, input logic o, input int cnt);
    chk({tag, "_err"}, 32'(ERR), 32'(e));
    chk({tag, "_ovf"}, 32'(OVF), 32'(o));
    chk({tag, "_count"}, 32'(COUNT), 32'(cnt));
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(IN_READY), 32'd0);
    chk({tag, "_we"}, 32'(MEM_WE), 32'd0);
    chk({tag, "_addr"}, 32'(MEM_ADDR), 32'd0);
    chk({tag, "_wdata"}, MEM_WDATA, 32'd0);
    chk({tag, "_done"}, 32'(DONE), 32'd0);
    status(tag, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; START = 1'b0; IN_VALID = 1'b0; LAST = 1'b0;
    KIND = '0; COND = '0; CMD = '0; S = 1'b0; RN = '0; RD = '0; RM = '0;
    IMM12 = '0; IMM24 = '0; addr_m = '0;
    repeat (3) @(negedge CLK);
    reset_vals("reset");
    RESET = 1'b0;
    @(negedge CLK);
    chk("stop_not_ready", 32'(IN_READY), 32'd0);

    // ADD immediate
    start_prog();
    send(KIND_DP_IMM, COND_AL, CMD_ADD, 1'b0, 4'd1, 4'd2, 4'd0, 12'h005, 24'h0, 1'b1, 1'b1, 32'hE2812005);
    wait_done();
    status("add", 1'b0, 1'b0, 1);

    // CMP register (RD forced to 0, S forced to 1) then STR
    start_prog();
    send(KIND_DP_REG, COND_AL, CMD_CMP, 1'b0, 4'd3, 4'd9, 4'd4, 12'h0, 24'h0, 1'b0, 1'b1, 32'hE1530004);
    send(KIND_STR, COND_AL, 4'd0, 1'b0, 4'd5, 4'd6, 4'd0, 12'h008, 24'h0, 1'b1, 1'b1, 32'hE5856008);
    wait_done();
    status("cmp_str", 1'b0, 1'b0, 2);

    // BX then BL; a START pulse while idle must not restart the program
    start_prog();
    send(KIND_BX, COND_AL, 4'd0, 1'b0, 4'd0, 4'd0, 4'd14, 12'h0, 24'h0, 1'b0, 1'b1, 32'hE12FFF1E);
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    send(KIND_BL, COND_AL, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h0, 24'h000010, 1'b1, 1'b1, 32'hEB000010);
    wait_done();
    status("bx_bl", 1'b0, 1'b0, 2);

    // Illegal records leave address and count untouched
    start_prog();
    send(KIND_DP_REG, COND_AL, 4'b1111, 1'b0, 4'd1, 4'd2, 4'd3, 12'h0, 24'h0, 1'b0, 1'b0, 32'h0);
    status("illegal_cmd", 1'b1, 1'b0, 0);
    send(KIND_ILL, COND_AL, CMD_ADD, 1'b0, 4'd1, 4'd2, 4'd3, 12'h0, 24'h0, 1'b0, 1'b0, 32'h0);
    send(KIND_LDR, COND_AL, 4'd0, 1'b0, 4'd2, 4'd3, 4'd0, 12'h010, 24'h0, 1'b1, 1'b1, 32'hE5923010);
    wait_done();
    status("illegal_then_ldr", 1'b1, 1'b0, 1);

    // Five writes into a four-word memory: wrap to 0 and sticky OVF
    start_prog();
    status("start_clears", 1'b0, 1'b0, 0);
    send(KIND_DP_REG, COND_AL, CMD_ORR, 1'b1, 4'd1, 4'd2, 4'd3, 12'h0, 24'h0, 1'b0, 1'b1, 32'hE1912003);
    send(KIND_DP_IMM, COND_AL, CMD_MOV, 1'b0, 4'd0, 4'd7, 4'd0, 12'h0FF, 24'h0, 1'b0, 1'b1, 32'hE3A070FF);
    send(KIND_DP_IMM, 4'b0000, CMD_SUB, 1'b1, 4'd4, 4'd5, 4'd0, 12'h123, 24'h0, 1'b0, 1'b1, 32'h02545123);
    send(KIND_DP_REG, 4'b0001, CMD_AND, 1'b0, 4'd8, 4'd9, 4'd10, 12'h0, 24'h0, 1'b0, 1'b1, 32'h1008900A);
    send(KIND_B, COND_AL, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h0, 24'hABCDEF, 1'b1, 1'b1, 32'hEAABCDEF);
    wait_done();
    status("wrap", 1'b0, 1'b1, 5);

    // Reset asserted during the write cycle
    start_prog();
    KIND = KIND_DP_REG; COND = COND_AL; CMD = CMD_ADD; S = 1'b0;
    RN = 4'd1; RD = 4'd1; RM = 4'd1; LAST = 1'b0; IN_VALID = 1'b1;
    sb_q.push_back({8'h00, 32'hE0811001});
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("write_before_reset", 32'(MEM_WE), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    reset_vals("reset_in_write");
    RESET = 1'b0;
    @(negedge CLK);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64: instruction-memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter AW, default 8: byte-address width of MEM_ADDR (AW >= log2(DEPTH)+2).
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port START  input  1  one-cycle pulse: begin a new program load at address 0.
REQ-006 SHALL have ports IN_VALID input 1 and IN_READY output 1: field-record handshake.
REQ-007 SHALL have port KIND  input  3  0 DP-reg, 1 DP-imm, 2 LDR, 3 STR, 4 B, 5 BL, 6 BX, 7 illegal.
REQ-008 SHALL have ports COND input 4 (bits 31:28), CMD input 4 (ALU command), S input 1 (flag-set bit).
REQ-009 SHALL have ports RN input 4, RD input 4, RM input 4, IMM12 input 12, IMM24 input 24.
REQ-010 SHALL have port LAST  input  1  record is the final program word.
REQ-011 SHALL have ports MEM_WE output 1, MEM_ADDR output AW, MEM_WDATA output 32: instruction-memory write port.
REQ-012 SHALL have ports DONE output 1, ERR output 1, OVF output 1, COUNT output log2(DEPTH)+1.

Function
REQ-013 FSM states SHALL be STOP, IDLE, WRITE, DONE; reset enters STOP.
REQ-014 STOP/DONE SHALL go to IDLE on START, clearing address, COUNT, ERR, OVF; START is ignored in IDLE/WRITE.
REQ-015 IN_READY SHALL be 1 only in IDLE; a record is accepted on IN_VALID&IN_READY and registered.
REQ-016 After an accepted legal record, the FSM SHALL be in WRITE for exactly one cycle: MEM_WE=1, MEM_WDATA=encoded word, MEM_ADDR=current address.
REQ-017 Latency: accept at cycle N -> MEM_WE at N+1 -> IN_READY at N+2 (or DONE at N+2 if LAST).
REQ-018 After each write, address SHALL increase by 4 and COUNT by 1; at address (DEPTH-1)*4 the next address SHALL wrap to 0 and OVF SHALL set (sticky).
REQ-019 Encoding common: [31:28]=COND; [27:26]=00 DP, 01 memory, 10 branch.
REQ-020 DP-imm: [25:20]={1,CMD,S'}, [19:16]=RN, [15:12]=RD, [11:0]=IMM12.
REQ-021 DP-reg: [25:20]={0,CMD,S'}, [19:16]=RN, [15:12]=RD, [11:4]=0, [3:0]=RM.
REQ-022 S' SHALL equal S, except CMP (CMD=1010) forces S'=1 and [15:12]=0.
REQ-023 Legal CMD SHALL be ADD 0100, SUB 0010, AND 0000, ORR 1100, MOV 1101, CMP 1010; any other CMD with KIND 0/1 is illegal.
REQ-024 LDR: [25:20]=011001; STR: [25:20]=011000; [19:16]=RN, [15:12]=RD, [11:0]=IMM12.
REQ-025 B: [25:24]=10; BL: [25:24]=11; [23:0]=IMM24.
REQ-026 BX: [27:4]=0x12FFF1, [3:0]=RM.
REQ-027 Illegal record: accepted, no MEM_WE, address/COUNT unchanged, ERR set (sticky), FSM returns to IDLE (or DONE if LAST).
REQ-028 LAST on an accepted record SHALL enter DONE after its write slot; DONE=1 while in DONE.
REQ-029 MEM_WE SHALL be 0 outside WRITE; MEM_WDATA/MEM_ADDR hold last values.

Reset
REQ-030 RESET SHALL override all inputs including START and an in-flight WRITE (MEM_WE low next cycle).
REQ-031 Reset values: state STOP, IN_READY 0, MEM_WE 0, MEM_ADDR 0, MEM_WDATA 0, DONE 0, ERR 0, OVF 0, COUNT 0.

Structure
REQ-032 Shared package SHALL hold KIND codes, ALU CMD codes, COND_AL=1110, Op class codes, BX pattern 0x12FFF1.
REQ-033 Combinational field packer SHALL be sub-module inst_encode (fields in -> word, illegal flag out); FSM, counters, registers in inst_loader.

Verification
REQ-034 START, DP-imm COND=1110 CMD=0100 S=0 RN=1 RD=2 IMM12=0x005 -> N+1: MEM_WE=1, ADDR=0, WDATA=0xE2812005.
REQ-035 DP-reg CMP RN=3 RM=4 S=0, then STR RN=5 RD=6 IMM12=8 LAST=1 -> 0xE1530004 at 0, 0xE5856008 at 4, DONE=1, COUNT=2.
REQ-036 BX RM=14 then BL IMM24=0x000010 -> 0xE12FFF1E at 0, 0xEB000010 at 4.
REQ-037 KIND=0 CMD=1111 -> no MEM_WE, ERR=1, next legal record still written at address 0.
REQ-038 DEPTH=4, five legal records -> fifth written at address 0, OVF=1, COUNT=5; RESET asserted during a WRITE cycle -> all outputs at reset values next cycle.
